alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// ------------------------------------------------------------------------
// Shares one multi-cycle ALU between two requesters. The arbiter grants
// one request at a time (round-robin on ties), drives the ALU from
// latched operands, follows the ALU busy flag through shift operations,
// and holds the result until the consumer takes it.
//
// Handshakes:
//   Request side: I_reqN_valid is a level. A request is accepted in the
//   cycle where O_reqN_ready is high. Ready is asserted combinationally,
//   only in IDLE, for at most one requester. The payload is sampled only
//   in that cycle, so a requester can drop valid without a grant and lose
//   nothing.
//   Response side: O_rsp_valid stays high with all response fields
//   stable until a cycle where I_rsp_ready is high. The arbiter then
//   returns to IDLE on the next cycle.
//
// Ports:
//   I_clk, I_reset          clock; synchronous active-high reset
//   I_reqN_valid/op/s1/s2   request N (N = 0,1)
//   O_reqN_ready            request N accepted this cycle
//   O_rsp_*                 held response (valid, id, data, flags, err)
//   I_rsp_ready             consumer takes the response
//   O_alu_en/op/s1/s2       ALU drive
//   O_alu_clr               one-cycle ALU reset pulse on a timeout abort
//   I_alu_*                 ALU result, busy and comparison flags
//   O_dbg_state             current FSM state, for observation only
// ------------------------------------------------------------------------
module alu_arbiter #(
    parameter int TIMEOUT = 40
) (
    input  logic        I_clk,
    input  logic        I_reset,

    input  logic        I_req0_valid,
    input  logic [3:0]  I_req0_op,
    input  logic [31:0] I_req0_s1,
    input  logic [31:0] I_req0_s2,
    output logic        O_req0_ready,

    input  logic        I_req1_valid,
    input  logic [3:0]  I_req1_op,
    input  logic [31:0] I_req1_s1,
    input  logic [31:0] I_req1_s2,
    output logic        O_req1_ready,

    output logic        O_rsp_valid,
    output logic        O_rsp_id,
    output logic [31:0] O_rsp_data,
    output logic        O_rsp_lt,
    output logic        O_rsp_ltu,
    output logic        O_rsp_eq,
    output logic        O_rsp_err,
    input  logic        I_rsp_ready,

    output logic        O_alu_en,
    output logic [3:0]  O_alu_op,
    output logic [31:0] O_alu_s1,
    output logic [31:0] O_alu_s2,
    output logic        O_alu_clr,
    input  logic [31:0] I_alu_data,
    input  logic        I_alu_busy,
    input  logic        I_alu_lt,
    input  logic        I_alu_ltu,
    input  logic        I_alu_eq,

    output logic [2:0]  O_dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        CHECK = 3'd2,
        SHIFT = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = TIMEOUT[CW-1:0];

    state_t         r_state;
    state_t         w_next;

    // r_last is the most recently granted requester; it doubles as the id
    // of the operation in flight. Reset value 1 makes requester 0 win the
    // first tie.
    logic           r_last;
    logic [3:0]     r_op;
    logic [31:0]    r_s1;
    logic [31:0]    r_s2;
    logic [CW-1:0]  r_cnt;

    logic           r_rsp_id;
    logic [31:0]    r_rsp_data;
    logic           r_rsp_lt;
    logic           r_rsp_ltu;
    logic           r_rsp_eq;
    logic           r_rsp_err;

    logic           w_grant0;
    logic           w_grant1;
    logic           w_alu_en;
    logic           w_alu_clr;
    logic           w_latch;
    logic           w_abort;

    // Next-state and per-state controls
    always_comb begin
        w_next    = r_state;
        w_grant0  = 1'b0;
        w_grant1  = 1'b0;
        w_alu_en  = 1'b0;
        w_alu_clr = 1'b0;
        w_latch   = 1'b0;
        w_abort   = 1'b0;

        case (r_state)
            IDLE: begin
                if (I_req0_valid && I_req1_valid) begin
                    // Tie: serve whoever was not served last.
                    w_grant0 = r_last;
                    w_grant1 = ~r_last;
                end else begin
                    w_grant0 = I_req0_valid;
                    w_grant1 = I_req1_valid;
                end
                if (I_req0_valid || I_req1_valid) begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                w_alu_en = 1'b1;
                w_next   = CHECK;
            end
            CHECK: begin
                if (I_alu_busy) begin
                    w_next = SHIFT;
                end else begin
                    w_latch = 1'b1;
                    w_next  = RESP;
                end
            end
            SHIFT: begin
                if (!I_alu_busy) begin
                    w_latch = 1'b1;
                    w_next  = RESP;
                end else if (r_cnt == TO_VAL) begin
                    w_alu_clr = 1'b1;
                    w_abort   = 1'b1;
                    w_next    = RESP;
                end else begin
                    // Enable tracks busy so the ALU keeps shifting and is
                    // never retriggered once it finishes.
                    w_alu_en = 1'b1;
                end
            end
            RESP: begin
                if (I_rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State, request latch and response registers
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_op       <= 4'd0;
            r_s1       <= 32'd0;
            r_s2       <= 32'd0;
            r_cnt      <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= 32'd0;
            r_rsp_lt   <= 1'b0;
            r_rsp_ltu  <= 1'b0;
            r_rsp_eq   <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_grant0) begin
                r_last <= 1'b0;
                r_op   <= I_req0_op;
                r_s1   <= I_req0_s1;
                r_s2   <= I_req0_s2;
            end else if (w_grant1) begin
                r_last <= 1'b1;
                r_op   <= I_req1_op;
                r_s1   <= I_req1_s1;
                r_s2   <= I_req1_s2;
            end

            // Counts SHIFT cycles; zero on entry and outside SHIFT.
            if (r_state == SHIFT && w_next == SHIFT) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (w_latch) begin
                r_rsp_id   <= r_last;
                r_rsp_data <= I_alu_data;
                r_rsp_lt   <= I_alu_lt;
                r_rsp_ltu  <= I_alu_ltu;
                r_rsp_eq   <= I_alu_eq;
                r_rsp_err  <= 1'b0;
            end else if (w_abort) begin
                r_rsp_id   <= r_last;
                r_rsp_data <= 32'd0;
                r_rsp_lt   <= 1'b0;
                r_rsp_ltu  <= 1'b0;
                r_rsp_eq   <= 1'b0;
                r_rsp_err  <= 1'b1;
            end
        end
    end

    // Combinational strobes are masked during reset: the state register
    // still holds the pre-reset state in that cycle.
    assign O_req0_ready = w_grant0 & ~I_reset;
    assign O_req1_ready = w_grant1 & ~I_reset;
    assign O_alu_en     = w_alu_en & ~I_reset;
    assign O_alu_clr    = w_alu_clr & ~I_reset;

    assign O_alu_op     = r_op;
    assign O_alu_s1     = r_s1;
    assign O_alu_s2     = r_s2;

    assign O_rsp_valid  = (r_state == RESP);
    assign O_rsp_id     = r_rsp_id;
    assign O_rsp_data   = r_rsp_data;
    assign O_rsp_lt     = r_rsp_lt;
    assign O_rsp_ltu    = r_rsp_ltu;
    assign O_rsp_eq     = r_rsp_eq;
    assign O_rsp_err    = r_rsp_err;

    assign O_dbg_state  = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// ------------------------------------------------------------------------
// Directed bench for alu_arbiter. A small behavioural ALU answers the
// arbiter: ADD/SUB complete one cycle after enable, SLL by n keeps busy
// high for n+2 cycles, and a stuck mode holds busy forever.
// ------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLL = 4'd2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd3;

    // ---------------- clock / reset ----------------
    logic        I_clk = 1'b0;
    logic        I_reset = 1'b1;
    always #5 I_clk = ~I_clk;

    logic        I_req0_valid = 1'b0;
    logic [3:0]  I_req0_op = 4'd0;
    logic [31:0] I_req0_s1 = 32'd0;
    logic [31:0] I_req0_s2 = 32'd0;
    logic        O_req0_ready;
    logic        I_req1_valid = 1'b0;
    logic [3:0]  I_req1_op = 4'd0;
    logic [31:0] I_req1_s1 = 32'd0;
    logic [31:0] I_req1_s2 = 32'd0;
    logic        O_req1_ready;
    logic        O_rsp_valid;
    logic        O_rsp_id;
    logic [31:0] O_rsp_data;
    logic        O_rsp_lt;
    logic        O_rsp_ltu;
    logic        O_rsp_eq;
    logic        O_rsp_err;
    logic        I_rsp_ready = 1'b1;
    logic        O_alu_en;
    logic [3:0]  O_alu_op;
    logic [31:0] O_alu_s1;
    logic [31:0] O_alu_s2;
    logic        O_alu_clr;
    logic [31:0] I_alu_data;
    logic        I_alu_busy;
    logic        I_alu_lt;
    logic        I_alu_ltu;
    logic        I_alu_eq;
    logic [2:0]  O_dbg_state;

    alu_arbiter #(.TIMEOUT(40)) dut (
        .I_clk(I_clk), .I_reset(I_reset),
        .I_req0_valid(I_req0_valid), .I_req0_op(I_req0_op),
        .I_req0_s1(I_req0_s1), .I_req0_s2(I_req0_s2), .O_req0_ready(O_req0_ready),
        .I_req1_valid(I_req1_valid), .I_req1_op(I_req1_op),
        .I_req1_s1(I_req1_s1), .I_req1_s2(I_req1_s2), .O_req1_ready(O_req1_ready),
        .O_rsp_valid(O_rsp_valid), .O_rsp_id(O_rsp_id), .O_rsp_data(O_rsp_data),
        .O_rsp_lt(O_rsp_lt), .O_rsp_ltu(O_rsp_ltu), .O_rsp_eq(O_rsp_eq),
        .O_rsp_err(O_rsp_err), .I_rsp_ready(I_rsp_ready),
        .O_alu_en(O_alu_en), .O_alu_op(O_alu_op), .O_alu_s1(O_alu_s1),
        .O_alu_s2(O_alu_s2), .O_alu_clr(O_alu_clr),
        .I_alu_data(I_alu_data), .I_alu_busy(I_alu_busy),
        .I_alu_lt(I_alu_lt), .I_alu_ltu(I_alu_ltu), .I_alu_eq(I_alu_eq),
        .O_dbg_state(O_dbg_state)
    );

    // ---------------- behavioural ALU ----------------
    logic        m_stuck = 1'b0;
    logic        m_busy;
    logic [5:0]  m_rem;
    logic [31:0] m_data;
    logic [31:0] m_pend;
    logic        m_lt, m_ltu, m_eq;

    always @(posedge I_clk) begin
        if (I_reset || O_alu_clr) begin
            m_busy <= 1'b0; m_rem <= 6'd0; m_data <= 32'd0; m_pend <= 32'd0;
            m_lt <= 1'b0; m_ltu <= 1'b0; m_eq <= 1'b0;
        end else if (O_alu_en && !m_busy) begin
            m_lt  <= $signed(O_alu_s1) < $signed(O_alu_s2);
            m_ltu <= O_alu_s1 < O_alu_s2;
            m_eq  <= O_alu_s1 == O_alu_s2;
            if (O_alu_op == OP_SLL) begin
                m_busy <= 1'b1;
                m_rem  <= {1'b0, O_alu_s2[4:0]} + 6'd2;
                m_pend <= O_alu_s1 << O_alu_s2[4:0];
            end else if (O_alu_op == OP_ADD) begin
                m_data <= O_alu_s1 + O_alu_s2;
            end else begin
                m_data <= O_alu_s1 - O_alu_s2;
            end
        end else if (m_busy && !m_stuck) begin
            if (m_rem == 6'd1) begin
                m_busy <= 1'b0;
                m_data <= m_pend;
            end else begin
                m_rem <= m_rem - 6'd1;
            end
        end
    end

    assign I_alu_busy = m_busy;
    assign I_alu_data = m_data;
    assign I_alu_lt   = m_lt;
    assign I_alu_ltu  = m_ltu;
    assign I_alu_eq   = m_eq;

    // ---------------- monitors ----------------
    int en_total = 0;
    int en_shift = 0;
    int en_nobusy = 0;
    int clr_cnt = 0;

    always @(posedge I_clk) begin
        if (O_alu_en) en_total <= en_total + 1;
        if (O_alu_en && O_dbg_state == ST_SHIFT) en_shift <= en_shift + 1;
        if (O_alu_en && O_dbg_state == ST_SHIFT && !m_busy) en_nobusy <= en_nobusy + 1;
        if (O_alu_clr) clr_cnt <= clr_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic set_req(input bit which, input logic [3:0] op,
                           input logic [31:0] s1, input logic [31:0] s2);
        if (which == 1'b0) begin
            I_req0_valid = 1'b1; I_req0_op = op; I_req0_s1 = s1; I_req0_s2 = s2;
        end else begin
            I_req1_valid = 1'b1; I_req1_op = op; I_req1_s1 = s1; I_req1_s2 = s2;
        end
    endtask

    // Called in the accept cycle (cycle 0). Returns the cycle in which
    // rsp_valid is first seen (-1 on timeout) and the first O_alu_clr cycle.
    task automatic wait_rsp(input int bound, input bit drop,
                            output int lat, output int clr_at);
        lat = -1;
        clr_at = -1;
        for (int c = 1; c <= bound; c++) begin
            tick();
            if (c == 1 && drop) begin
                I_req0_valid = 1'b0;
                I_req1_valid = 1'b0;
            end
            if (O_alu_clr && clr_at < 0) clr_at = c;
            if (O_rsp_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int lat, clr_at;
    int s_total, s_shift, s_nobusy, s_clr;

    initial begin
        // ---- reset state ----
        I_reset = 1'b1;
        tick();
        tick();
        check("rst_rsp_valid", {31'd0, O_rsp_valid}, 32'd0);
        check("rst_rsp_data", O_rsp_data, 32'd0);
        check("rst_rsp_err", {31'd0, O_rsp_err}, 32'd0);
        check("rst_rsp_id", {31'd0, O_rsp_id}, 32'd0);
        check("rst_state", {29'd0, O_dbg_state}, {29'd0, ST_IDLE});
        check("rst_alu_clr", {31'd0, O_alu_clr}, 32'd0);
        set_req(1'b0, OP_ADD, 32'd5, 32'd7);
        #1;
        check("rst_ready0", {31'd0, O_req0_ready}, 32'd0);

        // ---- single ADD 5+7 ----
        I_reset = 1'b0;
        s_total = en_total;
        #1;
        check("add_ready0", {31'd0, O_req0_ready}, 32'd1);
        check("add_ready1", {31'd0, O_req1_ready}, 32'd0);
        wait_rsp(10, 1'b1, lat, clr_at);
        check("add_latency", lat, 32'd3);
        check("add_data", O_rsp_data, 32'd12);
        check("add_id", {31'd0, O_rsp_id}, 32'd0);
        check("add_eq", {31'd0, O_rsp_eq}, 32'd0);
        check("add_lt", {31'd0, O_rsp_lt}, 32'd1);
        check("add_err", {31'd0, O_rsp_err}, 32'd0);
        check("add_en_cycles", en_total - s_total, 32'd1);
        check("add_alu_s1_held", O_alu_s1, 32'd5);
        tick();
        check("add_back_idle", {29'd0, O_dbg_state}, {29'd0, ST_IDLE});
        check("add_rsp_dropped", {31'd0, O_rsp_valid}, 32'd0);

        // ---- round-robin on ties, fresh from reset ----
        I_reset = 1'b1;
        tick();
        I_reset = 1'b0;
        set_req(1'b0, OP_SUB, 32'd3, 32'd3);
        set_req(1'b1, OP_SUB, 32'd3, 32'd3);
        #1;
        check("rr1_ready0", {31'd0, O_req0_ready}, 32'd1);
        check("rr1_ready1", {31'd0, O_req1_ready}, 32'd0);
        wait_rsp(10, 1'b0, lat, clr_at);
        check("rr1_latency", lat, 32'd3);
        check("rr1_data", O_rsp_data, 32'd0);
        check("rr1_eq", {31'd0, O_rsp_eq}, 32'd1);
        check("rr1_id", {31'd0, O_rsp_id}, 32'd0);
        check("rr1_no_ready_in_resp", {30'd0, O_req0_ready, O_req1_ready}, 32'd0);
        tick();
        check("rr2_ready1", {31'd0, O_req1_ready}, 32'd1);
        check("rr2_ready0", {31'd0, O_req0_ready}, 32'd0);
        wait_rsp(10, 1'b0, lat, clr_at);
        check("rr2_latency", lat, 32'd3);
        check("rr2_id", {31'd0, O_rsp_id}, 32'd1);
        check("rr2_eq", {31'd0, O_rsp_eq}, 32'd1);
        tick();
        check("rr3_ready0", {31'd0, O_req0_ready}, 32'd1);
        check("rr3_ready1", {31'd0, O_req1_ready}, 32'd0);
        wait_rsp(10, 1'b1, lat, clr_at);
        check("rr3_id", {31'd0, O_rsp_id}, 32'd0);
        tick();

        // ---- req1 SLL 1 by 31 ----
        s_total = en_total; s_shift = en_shift; s_nobusy = en_nobusy;
        set_req(1'b1, OP_SLL, 32'd1, 32'd31);
        #1;
        check("sll_ready1", {31'd0, O_req1_ready}, 32'd1);
        check("sll_ready0", {31'd0, O_req0_ready}, 32'd0);
        wait_rsp(60, 1'b1, lat, clr_at);
        check("sll_latency", lat, 32'd36);
        check("sll_data", O_rsp_data, 32'h8000_0000);
        check("sll_id", {31'd0, O_rsp_id}, 32'd1);
        check("sll_ltu", {31'd0, O_rsp_ltu}, 32'd1);
        check("sll_err", {31'd0, O_rsp_err}, 32'd0);
        check("sll_en_in_shift", en_shift - s_shift, 32'd32);
        check("sll_en_after_busy", en_nobusy - s_nobusy, 32'd0);
        check("sll_en_total", en_total - s_total, 32'd33);
        check("sll_alu_s2_held", O_alu_s2, 32'd31);
        tick();

        // ---- timeout: ALU busy forever ----
        m_stuck = 1'b1;
        s_clr = clr_cnt;
        set_req(1'b0, OP_SLL, 32'd1, 32'd5);
        #1;
        check("to_ready0", {31'd0, O_req0_ready}, 32'd1);
        wait_rsp(80, 1'b1, lat, clr_at);
        check("to_clr_cycle", clr_at, 32'd43);
        check("to_latency", lat, 32'd44);
        check("to_clr_count", clr_cnt - s_clr, 32'd1);
        check("to_err", {31'd0, O_rsp_err}, 32'd1);
        check("to_data", O_rsp_data, 32'd0);
        check("to_flags", {29'd0, O_rsp_lt, O_rsp_ltu, O_rsp_eq}, 32'd0);
        check("to_id", {31'd0, O_rsp_id}, 32'd0);
        m_stuck = 1'b0;
        tick();

        // ---- response held with consumer stalled ----
        I_rsp_ready = 1'b0;
        set_req(1'b0, OP_ADD, 32'd10, 32'd20);
        #1;
        check("hold_ready0", {31'd0, O_req0_ready}, 32'd1);
        wait_rsp(10, 1'b1, lat, clr_at);
        check("hold_latency", lat, 32'd3);
        set_req(1'b0, OP_ADD, 32'd1, 32'd1);
        set_req(1'b1, OP_ADD, 32'd100, 32'd200);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("hold_no_ready", {30'd0, O_req0_ready, O_req1_ready}, 32'd0);
            check("hold_valid", {31'd0, O_rsp_valid}, 32'd1);
            check("hold_data", O_rsp_data, 32'd30);
            check("hold_id", {31'd0, O_rsp_id}, 32'd0);
            tick();
        end
        I_rsp_ready = 1'b1;
        tick();
        check("hold_idle", {29'd0, O_dbg_state}, {29'd0, ST_IDLE});
        check("hold_next_ready1", {31'd0, O_req1_ready}, 32'd1);
        check("hold_next_ready0", {31'd0, O_req0_ready}, 32'd0);
        wait_rsp(10, 1'b1, lat, clr_at);
        check("hold_next_latency", lat, 32'd3);
        check("hold_next_id", {31'd0, O_rsp_id}, 32'd1);
        check("hold_next_data", O_rsp_data, 32'd300);
        tick();

        // ---- reset during SHIFT ----
        set_req(1'b0, OP_SLL, 32'd1, 32'd10);
        tick();
        I_req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_in_shift", {29'd0, O_dbg_state}, {29'd0, ST_SHIFT});
        I_reset = 1'b1;
        set_req(1'b1, OP_ADD, 32'd9, 32'd9);
        #1;
        check("mid_rst_en", {31'd0, O_alu_en}, 32'd0);
        check("mid_rst_ready1", {31'd0, O_req1_ready}, 32'd0);
        tick();
        I_reset = 1'b0;
        I_req1_valid = 1'b0;
        check("mid_idle", {29'd0, O_dbg_state}, {29'd0, ST_IDLE});
        check("mid_rsp_valid", {31'd0, O_rsp_valid}, 32'd0);
        check("mid_alu_en", {31'd0, O_alu_en}, 32'd0);
        set_req(1'b0, OP_ADD, 32'd2, 32'd3);
        set_req(1'b1, OP_ADD, 32'd4, 32'd4);
        #1;
        check("mid_tie_ready0", {31'd0, O_req0_ready}, 32'd1);
        wait_rsp(10, 1'b1, lat, clr_at);
        check("mid_latency", lat, 32'd3);
        check("mid_data", O_rsp_data, 32'd5);
        check("mid_id", {31'd0, O_rsp_id}, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
